display_scheduler: RTL and testbench
====================================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameters SHALL be, one per line:
- N, 16, data width of each requester value.
- NREQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 50_000_000, minimum cycles a granted value stays displayed.
- TIMEOUT, 64, maximum cycles to wait for converter completion.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single system clock.
- reset, in, 1, asynchronous active-low reset.
- req, in, NREQ, per-requester display request level.
- req_data, in, NREQ*N, packed values; requester i occupies bits [i*N+N-1 : i*N].
- req_fmt, in, NREQ, per-requester format; 0 = hex, 1 = decimal.
- grant, out, NREQ, one-hot owner of the display; all-zero when no owner.
- conv_trigger, out, 1, one-cycle start pulse to the binary-to-BCD converter.
- conv_in, out, 32, zero-extended latched value sent to the converter.
- conv_idle, in, 1, converter idle/done flag.
- conv_bcd, in, 32, converter BCD result.
- disp_digits, out, 32, nibble-per-digit word fed to the 7-segment driver.
- busy, out, 1, high in every state except IDLE and SHOW.
- err, out, 1, sticky flag set on converter timeout.

REQ-003 Clock and reset SHALL be: one clock `clk`; reset `reset` is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, CONV, WAIT, SHOW.

REQ-005 Arbitration SHALL be round-robin, evaluated only in IDLE and at SHOW expiry. Search starts at (last owner + 1) mod NREQ; after reset, search starts at requester 0.

REQ-006 On grant, the block SHALL latch the owner's req_data and req_fmt in the same cycle. Later changes to req, req_data or req_fmt SHALL NOT affect the displayed value until the next grant.

REQ-007 IDLE with any req bit high:
- fmt = 0: go to SHOW next cycle, with disp_digits = {zeros, latched data}. Latency from grant to update is 1 cycle.
- fmt = 1: go to CONV.

REQ-008 CONV SHALL last 1 cycle, with conv_trigger = 1 and conv_in = {zeros, latched data}. It then goes to WAIT. conv_trigger SHALL be 0 in every other state.

REQ-009 WAIT SHALL ignore conv_idle in its first cycle. From the second cycle onward, conv_idle = 1 SHALL capture conv_bcd into disp_digits and move to SHOW.

REQ-010 WAIT timeout: if conv_idle has not been accepted after TIMEOUT cycles in WAIT, the block SHALL set err, load disp_digits = 32'hEEEEEEEE and go to SHOW. err SHALL clear only on reset.

REQ-011 SHOW SHALL load a hold counter with HOLD_CYCLES-1 on entry and decrement it every cycle. At zero:
- any req high: re-arbitrate per REQ-005 and go to CONV, or to SHOW as in REQ-007.
- no req high: go to IDLE. disp_digits SHALL retain the last value, and grant SHALL retain the last owner.

REQ-012 If the only active requester is the current owner, it SHALL be re-granted at SHOW expiry, and its data SHALL be re-latched.

REQ-013 A requester that deasserts req during CONV, WAIT or SHOW SHALL keep grant until SHOW expiry; there is no pre-emption.

REQ-014 In IDLE with all req low, grant SHALL hold its last value, and the FSM SHALL stay in IDLE.

REQ-015 Width rule: zero-extension from N to 32 bits SHALL apply for every N <= 32. For N = 32, the value passes unmodified.

Reset
REQ-016 When reset = 0, asynchronously:
- state = IDLE, grant = 0, disp_digits = 32'h0, conv_in = 0, conv_trigger = 0.
- busy = 0, err = 0, hold counter = 0, round-robin pointer = 0.

REQ-017 Reset asserted mid-CONV, mid-WAIT or mid-SHOW SHALL abort the operation immediately. No conv_trigger SHALL be issued after reset release until a new grant.

REQ-018 After reset release, the first arbitration SHALL occur on the first rising clk edge with reset = 1.

Verification
REQ-019 Hex path: req = 4'b0001, req_data[15:0] = 16'hBEEF, fmt = 0 -> grant = 0001 and disp_digits = 32'h0000BEEF one cycle after the grant; conv_trigger never pulses.

REQ-020 Decimal path, with a bench converter model of 5-cycle latency: req = 4'b0100, data = 16'd1234, fmt = 1 -> one conv_trigger pulse with conv_in = 32'd1234; disp_digits = 32'h00001234 when conv_idle returns; busy high for the whole CONV and WAIT interval.

REQ-021 Round-robin, with HOLD_CYCLES = 4 and req = 4'b1111 constant -> grant sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles in SHOW.

REQ-022 Timeout, with TIMEOUT = 8 and conv_idle held 0 -> after 8 WAIT cycles, err = 1 and disp_digits = 32'hEEEEEEEE; err stays 1 until reset.

REQ-023 Reset mid-WAIT: assert reset = 0 during WAIT -> all outputs reach their reset values without a clock edge; no further conv_trigger until a new req.

REQ-024 No pre-emption: owner 0 drops req during SHOW while requester 2 raises req -> grant stays 0001 until expiry, then changes to 0100; disp_digits is unchanged until then.

Source files
------------

// File: rtl/display_scheduler.sv
// display_scheduler: round-robin owner of a 7-segment display, showing hex directly
// or a value sent through an external binary-to-BCD converter.
module display_scheduler #(
  parameter int N           = 16,
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_data,
  input  logic [NREQ-1:0]   req_fmt,
  output logic [NREQ-1:0]   grant,
  output logic              conv_trigger,
  output logic [31:0]       conv_in,
  input  logic              conv_idle,
  input  logic [31:0]       conv_bcd,
  output logic [31:0]       disp_digits,
  output logic              busy,
  output logic              err
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, CONV, WAIT, SHOW} state_t;
  state_t state;
  logic [PW-1:0] ptr, pick, idx;
  logic pick_any, arb, hex_pend;
  logic [N-1:0] lat, pdata;
  logic [HW-1:0] hold;
  logic [TW-1:0] wcnt;
  // scan downwards so the requester closest after the pointer wins
  always_comb begin
    pick = '0;
    idx = '0;
    pick_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (req[idx]) begin
        pick = idx;
        pick_any = 1'b1;
      end
    end
  end
  assign pdata = N'(req_data >> (pick * N));
  assign arb = state == IDLE || (state == SHOW && hold == '0);
  assign busy = state == CONV || state == WAIT;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      disp_digits <= '0;
      conv_in <= '0;
      conv_trigger <= 1'b0;
      err <= 1'b0;
      hold <= '0;
      ptr <= '0;
      wcnt <= '0;
      lat <= '0;
      hex_pend <= 1'b0;
    end else begin
      conv_trigger <= 1'b0;
      hex_pend <= 1'b0;
      if (hex_pend) disp_digits <= 32'(lat);
      if (arb && pick_any) begin
        grant <= NREQ'(1) << pick;
        ptr <= pick == PW'(NREQ - 1) ? '0 : pick + 1'b1;
        lat <= pdata;
        if (req_fmt[pick]) begin
          state <= CONV;
          conv_trigger <= 1'b1;
          conv_in <= 32'(pdata);
        end else begin
          state <= SHOW;
          hex_pend <= 1'b1;
          hold <= HW'(HOLD_CYCLES - 1);
        end
      end else begin
        case (state)
          CONV: begin
            state <= WAIT;
            wcnt <= '0;
          end
          WAIT: begin
            if (wcnt != '0 && conv_idle) begin
              disp_digits <= conv_bcd;
              state <= SHOW;
              hold <= HW'(HOLD_CYCLES - 1);
            end else if (wcnt == TW'(TIMEOUT - 1)) begin
              err <= 1'b1;
              disp_digits <= 32'hEEEE_EEEE;
              state <= SHOW;
              hold <= HW'(HOLD_CYCLES - 1);
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
          SHOW: begin
            if (hold == '0) state <= IDLE;
            else hold <= hold - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed checks of hex, decimal, round-robin, timeout and reset behaviour.
module tb_display_scheduler;
  localparam int N = 16;
  localparam int NREQ = 4;
  localparam int HOLD = 4;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] req_fmt = '0;
  logic [NREQ*N-1:0] req_data = '0;
  logic [NREQ-1:0] grant;
  logic conv_trigger;
  logic [31:0] conv_in;
  logic conv_idle = 1'b1;
  logic [31:0] conv_bcd = '0;
  logic [31:0] disp_digits;
  logic busy, err;
  int total = 0;
  int bad = 0;
  int trig_cnt = 0;
  int cnt = 0;
  int t0, n;
  bit conv_dead = 1'b0;

  display_scheduler #(.N(N), .NREQ(NREQ), .HOLD_CYCLES(HOLD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_fmt(req_fmt),
    .grant(grant), .conv_trigger(conv_trigger), .conv_in(conv_in), .conv_idle(conv_idle),
    .conv_bcd(conv_bcd), .disp_digits(disp_digits), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int d = 0; d < 8; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // converter model: drops idle on a trigger, returns the BCD result 5 cycles later
  always @(negedge clk) begin
    if (conv_trigger) begin
      trig_cnt++;
      cnt = 5;
      conv_idle = 1'b0;
    end else if (cnt > 0 && !conv_dead) begin
      cnt--;
      if (cnt == 0) begin
        conv_idle = 1'b1;
        conv_bcd = to_bcd(conv_in);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic run_busy(output int cycles);
    cycles = 0;
    for (int k = 0; k < 30 && busy; k++) begin
      cycles++;
      tick();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_disp"}, disp_digits, 32'h0);
    chk({tag, "_conv_in"}, conv_in, 32'h0);
    chk({tag, "_trig"}, 32'(conv_trigger), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    #2;
    chk_reset_vals("rst");
    tick();
    reset = 1'b1;
    // hex path
    req = 4'b0001;
    req_data[15:0] = 16'hBEEF;
    req_fmt = '0;
    t0 = trig_cnt;
    tick();
    chk("hex_grant", 32'(grant), 32'h1);
    chk("hex_busy", 32'(busy), 32'h0);
    tick();
    chk("hex_disp", disp_digits, 32'h0000_BEEF);
    req = '0;
    repeat (6) tick();
    chk("idle_grant_hold", 32'(grant), 32'h1);
    chk("idle_disp_hold", disp_digits, 32'h0000_BEEF);
    chk("hex_no_trig", 32'(trig_cnt), 32'(t0));
    // decimal path
    req = 4'b0100;
    req_data[47:32] = 16'd1234;
    req_fmt = 4'b0100;
    t0 = trig_cnt;
    tick();
    chk("dec_grant", 32'(grant), 32'h4);
    chk("dec_trig", 32'(conv_trigger), 32'h1);
    chk("dec_conv_in", conv_in, 32'd1234);
    req = '0;
    run_busy(n);
    chk("dec_busy_len", 32'(n), 32'd6);
    chk("dec_disp", disp_digits, 32'h0000_1234);
    chk("dec_trig_cnt", 32'(trig_cnt), 32'(t0 + 1));
    chk("dec_grant_kept", 32'(grant), 32'h4);
    repeat (6) tick();
    // round robin
    req_fmt = '0;
    req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    do_reset();
    req = 4'hF;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'(1) << ((k / 4) % 4));
      if (k % 4 == 3) chk("rr_disp", disp_digits, 32'(32'h1111 * ((k / 4) % 4 + 1)));
    end
    req = '0;
    // no pre-emption, latched data immune to later changes
    do_reset();
    req = 4'b0001;
    req_data[15:0] = 16'hAAAA;
    tick();
    chk("np_grant0", 32'(grant), 32'h1);
    req = 4'b0100;
    req_data[15:0] = 16'h5555;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("np_grant_kept", 32'(grant), 32'h1);
      chk("np_disp_kept", disp_digits, 32'h0000_AAAA);
    end
    tick();
    chk("np_grant_new", 32'(grant), 32'h4);
    chk("np_disp_old", disp_digits, 32'h0000_AAAA);
    tick();
    chk("np_disp_new", disp_digits, 32'h0000_3333);
    req = '0;
    // converter timeout
    do_reset();
    conv_dead = 1'b1;
    req = 4'b0100;
    req_fmt = 4'b0100;
    req_data[47:32] = 16'd1234;
    tick();
    chk("to_trig", 32'(conv_trigger), 32'h1);
    run_busy(n);
    chk("to_busy_len", 32'(n), 32'd9);
    chk("to_err", 32'(err), 32'h1);
    chk("to_disp", disp_digits, 32'hEEEE_EEEE);
    req = '0;
    repeat (10) tick();
    chk("to_err_sticky", 32'(err), 32'h1);
    chk("to_disp_kept", disp_digits, 32'hEEEE_EEEE);
    // reset in the middle of WAIT
    req = 4'b0100;
    tick();
    chk("rw_trig", 32'(conv_trigger), 32'h1);
    tick();
    tick();
    chk("rw_busy", 32'(busy), 32'h1);
    req = '0;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("rw");
    t0 = trig_cnt;
    tick();
    reset = 1'b1;
    repeat (8) tick();
    chk("rw_no_trig", 32'(trig_cnt), 32'(t0));
    chk("rw_busy_after", 32'(busy), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
